// File: rtl/sha256_msg_pad_if.sv
// Byte-stream and block-stream bundle between a message source, the
// SHA-256 padder and the compression core.
//
// Handshake: both streams use valid/ready. A transfer happens on a rising
// clock edge where valid and ready are both high. Once valid is raised, the
// sender holds the payload stable and keeps valid high until that transfer.
// Ready may be raised or lowered at any time and never depends on valid.
interface sha256_msg_pad_if;
   logic [31:0]  din;
   logic         din_vld;
   logic         din_rdy;
   logic         din_last;
   logic [2:0]   din_nbytes;
   logic [511:0] blk_data;
   logic         blk_vld;
   logic         blk_rdy;
   logic         blk_first;
   logic         blk_last;

   // Message source and block consumer side
   modport master (
      output din, din_vld, din_last, din_nbytes, blk_rdy,
      input  din_rdy, blk_data, blk_vld, blk_first, blk_last
   );

   // Padder side
   modport slave (
      input  din, din_vld, din_last, din_nbytes, blk_rdy,
      output din_rdy, blk_data, blk_vld, blk_first, blk_last
   );
endinterface

// File: rtl/sha256_msg_pad.sv
// SHA-256 message padder. It collects 32-bit big-endian message words into a
// 16-word buffer. It inserts the 0x80 marker, the zero fill and the 64-bit bit
// length, and hands complete 512-bit blocks to the compression core.
module sha256_msg_pad (
   input  logic                   clk,
   input  logic                   rst,
   sha256_msg_pad_if.slave        bus,
   output logic [1:0]             state_dbg
);

   typedef enum logic [1:0] {FILL, PAD, EMIT, LEN} state_t;

   state_t       state;
   logic [31:0]  words [16];
   logic [3:0]   widx;      // next buffer word to write
   logic [3:0]   p_idx;     // word that holds (or will hold) the 0x80 marker
   logic [63:0]  bitlen;
   logic         first;     // next emitted block starts a message
   logic         need_len;  // length did not fit, a length-only block follows
   logic         pend80;    // marker did not fit, it opens the next block
   logic         mark_p;    // PAD must write 0x80000000 into word p_idx
   logic         vld_q;
   logic         first_q;
   logic         last_q;
   logic [2:0]   n_eff;
   logic [31:0]  last_word;
   logic [511:0] blk_flat;
   logic         in_xfer;
   logic         out_xfer;

   assign bus.din_rdy   = (state == FILL) & ~rst;
   assign in_xfer       = bus.din_vld & bus.din_rdy;
   assign out_xfer      = vld_q & bus.blk_rdy;
   assign bus.blk_vld   = vld_q;
   assign bus.blk_first = first_q;
   assign bus.blk_last  = last_q;
   assign bus.blk_data  = blk_flat;
   assign state_dbg     = state;

   // Clamp the byte count and build the final word with its 0x80 marker
   always_comb begin
      n_eff = (bus.din_nbytes > 3'd4) ? 3'd4 : bus.din_nbytes;
      case (n_eff)
         3'd0:    last_word = 32'h8000_0000;
         3'd1:    last_word = {bus.din[31:24], 24'h80_0000};
         3'd2:    last_word = {bus.din[31:16], 16'h8000};
         3'd3:    last_word = {bus.din[31:8], 8'h80};
         default: last_word = bus.din;
      endcase
   end

   // Flatten the buffer so that word 0 sits in the top 32 bits
   always_comb begin
      blk_flat = '0;
      for (int i = 0; i < 16; i++) begin
         blk_flat[511-32*i -: 32] = words[i];
      end
   end

   // Padding FSM: accept words, pad, emit, add a length-only block if needed
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FILL;
         widx     <= 4'd0;
         p_idx    <= 4'd0;
         bitlen   <= 64'd0;
         first    <= 1'b1;
         need_len <= 1'b0;
         pend80   <= 1'b0;
         mark_p   <= 1'b0;
         vld_q    <= 1'b0;
         first_q  <= 1'b0;
         last_q   <= 1'b0;
         for (int i = 0; i < 16; i++) words[i] <= 32'd0;
      end else begin
         case (state)
            FILL: begin
               if (in_xfer) begin
                  if (!bus.din_last) begin
                     words[widx] <= bus.din;
                     bitlen      <= bitlen + 64'd32;
                     if (widx == 4'd15) begin
                        state   <= EMIT;
                        vld_q   <= 1'b1;
                        first_q <= first;
                        last_q  <= 1'b0;
                     end else begin
                        widx <= widx + 4'd1;
                     end
                  end else begin
                     words[widx] <= last_word;
                     bitlen      <= bitlen + {58'd0, n_eff, 3'd0};
                     state       <= PAD;
                     if (n_eff == 3'd4) begin
                        // A full final word pushes the marker into the next word
                        if (widx == 4'd15) begin
                           pend80 <= 1'b1;
                        end else begin
                           p_idx  <= widx + 4'd1;
                           mark_p <= 1'b1;
                        end
                     end else begin
                        p_idx  <= widx;
                        mark_p <= 1'b0;
                     end
                  end
               end
            end
            PAD: begin
               state   <= EMIT;
               vld_q   <= 1'b1;
               first_q <= first;
               if (pend80) begin
                  // The buffer is full of data; the marker opens the next block
                  last_q <= 1'b0;
               end else begin
                  if (mark_p) words[p_idx] <= 32'h8000_0000;
                  for (int i = 0; i < 16; i++) begin
                     if (4'(i) > p_idx) words[i] <= 32'd0;
                  end
                  if (p_idx <= 4'd13) begin
                     words[14] <= bitlen[63:32];
                     words[15] <= bitlen[31:0];
                     last_q    <= 1'b1;
                  end else begin
                     last_q   <= 1'b0;
                     need_len <= 1'b1;
                  end
               end
            end
            EMIT: begin
               if (out_xfer) begin
                  vld_q <= 1'b0;
                  first <= 1'b0;
                  widx  <= 4'd0;
                  if (need_len) begin
                     state <= LEN;
                  end else if (pend80) begin
                     pend80 <= 1'b0;
                     p_idx  <= 4'd0;
                     mark_p <= 1'b1;
                     state  <= PAD;
                  end else begin
                     state <= FILL;
                     if (last_q) begin
                        bitlen <= 64'd0;
                        first  <= 1'b1;
                     end
                  end
               end
            end
            LEN: begin
               for (int i = 0; i < 14; i++) words[i] <= 32'd0;
               words[14] <= bitlen[63:32];
               words[15] <= bitlen[31:0];
               need_len  <= 1'b0;
               state     <= EMIT;
               vld_q     <= 1'b1;
               first_q   <= first;
               last_q    <= 1'b1;
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_msg_pad.sv
// Bench for sha256_msg_pad. A reference model builds the FIPS 180-4 padded
// byte string of each message, cuts it into 64-byte blocks and queues them.
// Directed tasks cover the timing and the literal cases.
module tb_sha256_msg_pad;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] state_dbg;

   sha256_msg_pad_if bus();

   sha256_msg_pad dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // Clock
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [511:0] exp_q[$];
   logic         exp_first_q[$];
   logic         exp_last_q[$];

   // Reference model: standard padding of a byte string, then 64-byte blocks
   task automatic model_push(input logic [7:0] msg[$]);
      logic [7:0]   p[$];
      logic [63:0]  bl;
      logic [511:0] blk;
      int           nb;
      p  = msg;
      bl = 64'(msg.size()) * 64'd8;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
      nb = p.size() / 64;
      for (int b = 0; b < nb; b++) begin
         blk = '0;
         for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
         exp_q.push_back(blk);
         exp_first_q.push_back(b == 0);
         exp_last_q.push_back(b == nb - 1);
      end
   endtask

   // Driver: split a message into words, with random idle gaps
   task automatic drive_msg(input logic [7:0] msg[$], input int gap_pct);
      int          nw;
      int          n;
      int          c;
      logic [31:0] w;
      nw = (msg.size() == 0) ? 1 : (msg.size() + 3) / 4;
      for (int k = 0; k < nw; k++) begin
         while ($urandom_range(0, 99) < gap_pct) begin
            bus.din_vld = 1'b0;
            bus.din     = $urandom;
            @(negedge clk);
         end
         n = (k == nw - 1) ? msg.size() - 4 * k : 4;
         w = $urandom;
         for (int b = 0; b < n; b++) w[31-8*b -: 8] = msg[4*k+b];
         bus.din      = w;
         bus.din_last = (k == nw - 1);
         if (k == nw - 1)
            bus.din_nbytes = (n == 4 && $urandom_range(0, 1) == 1) ?
                             3'($urandom_range(5, 7)) : 3'(n);
         else
            bus.din_nbytes = 3'($urandom);
         bus.din_vld = 1'b1;
         c = 0;
         while (bus.din_rdy !== 1'b1 && c < 4000) begin
            @(negedge clk);
            c++;
         end
         if (c >= 4000) begin
            n_tests++;
            n_fail++;
            $display("FAIL din_timeout: din_rdy stayed %b, required 1", bus.din_rdy);
         end
         @(negedge clk);
      end
      bus.din_vld  = 1'b0;
      bus.din_last = 1'b0;
   endtask

   // Consumer: accepts blocks with random or fixed stalls and checks them
   task automatic collect(input int nblk, input bit bp);
      int           got = 0;
      int           cyc = 0;
      int           hold = 0;
      bit           have_held = 0;
      logic [511:0] held_d;
      logic         held_f;
      logic         held_l;
      logic [511:0] ed;
      logic         ef;
      logic         el;
      while (got < nblk && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (bus.blk_vld === 1'b1) begin
            if (have_held) begin
               n_tests++;
               if (bus.blk_data !== held_d || bus.blk_first !== held_f ||
                   bus.blk_last !== held_l) begin
                  n_fail++;
                  $display("FAIL blk_stable: got %h/%b/%b required %h/%b/%b",
                           bus.blk_data, bus.blk_first, bus.blk_last, held_d, held_f, held_l);
               end
            end else begin
               held_d    = bus.blk_data;
               held_f    = bus.blk_first;
               held_l    = bus.blk_last;
               have_held = 1;
               hold      = bp ? 5 : $urandom_range(0, 2);
            end
            if (bp) begin
               n_tests++;
               if (bus.din_rdy !== 1'b0) begin
                  n_fail++;
                  $display("FAIL din_rdy_in_emit: got %b required 0", bus.din_rdy);
               end
            end
            if (hold > 0) begin
               bus.blk_rdy = 1'b0;
               hold--;
            end else begin
               bus.blk_rdy = 1'b1;
               got++;
               have_held = 0;
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL extra_block: got %h, required no block", bus.blk_data);
               end else begin
                  ed = exp_q.pop_front();
                  ef = exp_first_q.pop_front();
                  el = exp_last_q.pop_front();
                  n_tests++;
                  if (bus.blk_data !== ed) begin
                     n_fail++;
                     $display("FAIL blk_data: got %h required %h", bus.blk_data, ed);
                  end
                  n_tests++;
                  if (bus.blk_first !== ef) begin
                     n_fail++;
                     $display("FAIL blk_first: got %b required %b", bus.blk_first, ef);
                  end
                  n_tests++;
                  if (bus.blk_last !== el) begin
                     n_fail++;
                     $display("FAIL blk_last: got %b required %b", bus.blk_last, el);
                  end
               end
            end
         end else begin
            if (have_held) begin
               n_tests++;
               n_fail++;
               $display("FAIL blk_vld_drop: got 0 required 1 before transfer");
            end
            have_held   = 0;
            bus.blk_rdy = bp ? 1'b0 : 1'($urandom_range(0, 1));
         end
      end
      n_tests++;
      if (got < nblk) begin
         n_fail++;
         $display("FAIL blk_timeout: got %0d blocks required %0d", got, nblk);
      end
      @(negedge clk);
      bus.blk_rdy = 1'b0;
   endtask

   task automatic run_msg(input logic [7:0] msg[$], input int gap_pct, input bit bp);
      int nb;
      exp_q.delete();
      exp_first_q.delete();
      exp_last_q.delete();
      model_push(msg);
      nb = exp_q.size();
      fork
         drive_msg(msg, gap_pct);
         collect(nb, bp);
      join
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL leftover: got %0d unconsumed expected blocks required 0", exp_q.size());
      end
   endtask

   task automatic make_msg(input int len, output logic [7:0] msg[$]);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if (bus.blk_vld !== 1'b0 || bus.blk_first !== 1'b0 || bus.blk_last !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got vld/first/last %b%b%b required 000",
                  bus.blk_vld, bus.blk_first, bus.blk_last);
      end
      n_tests++;
      if (bus.blk_data !== 512'd0) begin
         n_fail++;
         $display("FAIL reset_data: got %h required 0", bus.blk_data);
      end
      n_tests++;
      if (bus.din_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_din_rdy: got %b required 0", bus.din_rdy);
      end
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.din_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_din_rdy: got %b required 1", bus.din_rdy);
      end
   endtask

   // Literal "abc", full-block and empty-tail cases with cycle-exact latency
   task automatic test_latency;
      logic [511:0] full;
      bus.blk_rdy    = 1'b0;
      bus.din        = 32'h6162_6300;
      bus.din_last   = 1'b1;
      bus.din_nbytes = 3'd3;
      bus.din_vld    = 1'b1;
      @(negedge clk);
      bus.din_vld  = 1'b0;
      bus.din_last = 1'b0;
      n_tests++;
      if (bus.blk_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL lat_pad_cycle: blk_vld got %b required 0", bus.blk_vld);
      end
      @(negedge clk);
      n_tests++;
      if (bus.blk_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL lat_abc: blk_vld got %b required 1", bus.blk_vld);
      end
      n_tests++;
      if (bus.blk_data !== {32'h6162_6380, 448'd0, 32'h0000_0018} ||
          bus.blk_first !== 1'b1 || bus.blk_last !== 1'b1) begin
         n_fail++;
         $display("FAIL abc_block: got %h/%b/%b required 61626380..00000018/1/1",
                  bus.blk_data, bus.blk_first, bus.blk_last);
      end
      bus.blk_rdy = 1'b1;
      @(negedge clk);
      bus.blk_rdy = 1'b0;
      full = '0;
      for (int k = 0; k < 16; k++) begin
         bus.din        = 32'h0100_0000 + 32'(k) * 32'h0001_0203;
         full[511-32*k -: 32] = bus.din;
         bus.din_last   = 1'b0;
         bus.din_nbytes = 3'd4;
         bus.din_vld    = 1'b1;
         @(negedge clk);
      end
      bus.din_vld = 1'b0;
      n_tests++;
      if (bus.blk_vld !== 1'b1 || bus.blk_data !== full ||
          bus.blk_first !== 1'b1 || bus.blk_last !== 1'b0) begin
         n_fail++;
         $display("FAIL full_block: got vld %b %h/%b/%b required vld 1 %h/1/0",
                  bus.blk_vld, bus.blk_data, bus.blk_first, bus.blk_last, full);
      end
      bus.blk_rdy = 1'b1;
      @(negedge clk);
      bus.blk_rdy    = 1'b0;
      bus.din        = $urandom;
      bus.din_last   = 1'b1;
      bus.din_nbytes = 3'd0;
      bus.din_vld    = 1'b1;
      @(negedge clk);
      bus.din_vld  = 1'b0;
      bus.din_last = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.blk_vld !== 1'b1 || bus.blk_data !== {32'h8000_0000, 448'd0, 32'h0000_0200} ||
          bus.blk_first !== 1'b0 || bus.blk_last !== 1'b1) begin
         n_fail++;
         $display("FAIL tail_block: got vld %b %h/%b/%b required vld 1 80000000..00000200/0/1",
                  bus.blk_vld, bus.blk_data, bus.blk_first, bus.blk_last);
      end
      bus.blk_rdy = 1'b1;
      @(negedge clk);
      bus.blk_rdy = 1'b0;
   endtask

   // Lengths around the one-block / two-block boundaries
   task automatic test_boundaries;
      logic [7:0] msg[$];
      int         lens[10] = '{0, 3, 4, 52, 55, 56, 60, 63, 64, 128};
      foreach (lens[i]) begin
         make_msg(lens[i], msg);
         run_msg(msg, 20, 1'b0);
      end
   endtask

   task automatic test_backpressure;
      logic [7:0] msg[$];
      make_msg(56, msg);
      run_msg(msg, 0, 1'b1);
      make_msg(64, msg);
      run_msg(msg, 0, 1'b1);
   endtask

   task automatic test_reset_mid;
      logic [7:0] msg[$];
      for (int k = 0; k < 5; k++) begin
         bus.din        = $urandom;
         bus.din_last   = 1'b0;
         bus.din_nbytes = 3'd4;
         bus.din_vld    = 1'b1;
         @(negedge clk);
      end
      bus.din_vld = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.blk_vld !== 1'b0 || bus.din_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_state: got vld %b rdy %b required 0 1", bus.blk_vld, bus.din_rdy);
      end
      msg = '{8'h61, 8'h62, 8'h63};
      run_msg(msg, 0, 1'b0);
   endtask

   task automatic test_back_to_back;
      logic [7:0] msg[$];
      for (int m = 0; m < 6; m++) begin
         make_msg($urandom_range(60, 130), msg);
         run_msg(msg, 0, 1'b0);
      end
   endtask

   task automatic test_random;
      logic [7:0] msg[$];
      for (int m = 0; m < 25; m++) begin
         make_msg($urandom_range(0, 200), msg);
         run_msg(msg, 30, 1'b0);
      end
   endtask

   // Watchdog against a hung run
   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      bus.din        = 32'd0;
      bus.din_vld    = 1'b0;
      bus.din_last   = 1'b0;
      bus.din_nbytes = 3'd0;
      bus.blk_rdy    = 1'b0;
      @(negedge clk);
      test_reset();
      test_latency();
      test_boundaries();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sha256_msg_pad.md
# sha256_msg_pad

Message formatter that sits directly upstream of the SHA-256 compression core. It accepts an arbitrary-length byte message as a stream of 32-bit big-endian words with a valid/ready handshake. It applies FIPS 180-4 padding: a 0x80 byte, zero fill, and the 64-bit message bit length. It emits complete 512-bit blocks, with first/last markers, for the core to consume.

## Interface
- No parameters; the geometry is fixed by SHA-256 (32-bit input word, 512-bit block, 64-bit length field).

- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- din  in  32  message word, big-endian; byte 0 at din[31:24].
- din_vld  in  1  din/din_last/din_nbytes valid.
- din_rdy  out  1  block can accept a word; transfer occurs when din_vld & din_rdy.
- din_last  in  1  final word of the message.
- din_nbytes  in  3  valid bytes in the final word, 0..4, left-aligned; ignored unless din_last. Non-last words always carry 4 bytes.
- blk_data  out  512  padded block; word 0 at [511:480], word 15 at [31:0].
- blk_vld  out  1  blk_data/blk_first/blk_last valid.
- blk_rdy  in  1  consumer accepts the block; transfer occurs when blk_vld & blk_rdy.
- blk_first  out  1  first block of the message; the core loads its IV.
- blk_last  out  1  final block of the message; the digest is ready after the core processes it.

## Operation
- State FILL: din_rdy=1.
  - Each accepted word is written to buffer word widx (0..15).
  - Non-last word: bitlen += 32.
    - widx != 15: widx++.
    - widx == 15: go to EMIT with blk_last=0.
  - Last word with n = din_nbytes: bitlen += 8n.
    - Bytes n..3 of the word are replaced by 0x80 followed by zeros.
    - If n=4, the 0x80 goes into word widx+1 instead.
    - Go to PAD.
- State PAD (one cycle): set p = index of the word holding 0x80.
  - Words p+1..15 are cleared.
  - If p ≤ 13: word14 = bitlen[63:32], word15 = bitlen[31:0], then EMIT with blk_last=1.
  - Else (p = 14 or 15): EMIT with blk_last=0, and set the need_len flag.
  - Edge case, n=4 at widx=15: the 0x80 does not fit, so the current block is emitted full (blk_last=0). The next block starts with word0 = 0x80000000 and then follows the PAD rules with p=0.
- State EMIT: blk_vld=1; blk_data, blk_first and blk_last are held stable until blk_rdy.
  - On transfer:
    - If need_len or a pending 0x80: go to LEN or PAD.
    - Else if blk_last: go to FILL with bitlen=0 and first=1.
    - Else: go to FILL with widx=0.
- State LEN (one cycle): the buffer is set to all zeros, plus word0 = 0x80000000 if pending, and word14/15 = bitlen. Then EMIT with blk_last=1.
- blk_first=1 only on the first block emitted after reset or after the previous blk_last transfer.
- bitlen is 64-bit and wraps mod 2^64; no error is flagged.
- Empty message (din_last with din_nbytes=0 at widx=0): emits one block, word0 = 0x80000000, all other words 0.
- din_nbytes > 4 with din_last: treated as 4.

## Timing
- Reset: state=FILL, widx=0, bitlen=0, first=1, need_len=0, blk_vld=0, blk_first=0, blk_last=0, blk_data=0. din_rdy=0 while rst=1.
- Reset mid-message discards all buffered words and any un-accepted block; the next cycle starts a fresh message.
- din_rdy = (state==FILL) & ~rst; combinational from state, with no dependency on din_vld.
- Latency:
  - 16th word accepted at cycle T: blk_vld=1 at T+1.
  - Last word accepted at T: blk_vld at T+2 (through PAD).
  - Second, length-only block: blk_vld 2 cycles after the first block transfers.
- Throughput: 16 input words plus 1 EMIT cycle per full block with blk_rdy tied high.
- blk_vld, once raised, does not drop until the transfer; blk outputs are registered.

## Test plan
- "abc": din=0x61626300, nbytes=3, last. Expect one block: word0=0x61626380, words1..14=0, word15=0x00000018, first=1, last=1.
- Empty message: last with nbytes=0. Expect word0=0x80000000, words1..15=0, first=1, last=1.
- 56-byte message (14 full words, last nbytes=4).
  - Block A: data in words 0..13, word14=0x80000000, word15=0, first=1, last=0.
  - Block B: all zero except word15=0x000001C0, first=0, last=1.
- 64-byte message.
  - Block A: full data, last=0.
  - Block B: word0=0x80000000, word15=0x00000200, last=1.
- Backpressure: hold blk_rdy=0 for 5 cycles on each block. Expect blk_vld=1 and blk_data stable throughout, din_rdy=0, and no input words lost.
- Reset mid-message: feed 5 words, assert rst for 1 cycle, then send "abc". Expect only the "abc" block (first=1, length 0x18), with no residue from the earlier words.
